// File: rtl/router_pkg.sv
// Shared types and defaults for the 1x3 byte-serial packet router.
package router_pkg;

  localparam int unsigned DEFAULT_DATA_W     = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 16;
  localparam int unsigned DEFAULT_TIMEOUT    = 30;

  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DecodeAddress,
    WaitTillEmpty,
    LoadFirstData,
    LoadData,
    CheckParityError,
    Discard
  } state_e;

  // Pick one of three per-port flags; the invalid address never selects a port.
  function automatic logic sel_port(input logic [2:0] flags, input logic [1:0] addr);
    logic res;
    case (addr)
      2'd0:    res = flags[0];
      2'd1:    res = flags[1];
      2'd2:    res = flags[2];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Output FIFO with first-word-fall-through head; SOFT_RESET_EN adds an idle-timeout flush.
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              header_flag,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              soft_reset
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            push, pop;
  logic [DATA_W:0] head;
  logic            unused_head_flag;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = write_enb & ~full;
  assign pop   = read_enb & ~empty;

  assign head             = mem_q[rd_ptr_q[AW-1:0]];
  assign data_out         = empty ? '0 : head[DATA_W-1:0];
  assign unused_head_flag = head[DATA_W];

`ifdef SOFT_RESET_EN
  logic [4:0] timer_q, timer_d;

  // Counts consecutive cycles the head sits visible but unread.
  always_comb begin
    timer_d    = timer_q;
    soft_reset = 1'b0;
    if (empty || pop) begin
      timer_d = '0;
    end else if (timer_q == 5'(TIMEOUT - 1)) begin
      soft_reset = 1'b1;
      timer_d    = '0;
    end else begin
      timer_d = timer_q + 5'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`else
  assign soft_reset = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {header_flag, data_in};
  end

endmodule

// File: rtl/router_1x3.sv
// 1-input, 3-output packet router: input FSM, header latch and parity check.
// Optional idle-timeout FIFO flush is enabled with SOFT_RESET_EN.
module router_1x3
  import router_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              read_enb_0,
  input  logic              read_enb_1,
  input  logic              read_enb_2,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic              vld_out_0,
  output logic              vld_out_1,
  output logic              vld_out_2,
  output logic              error,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] header_q, header_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [DATA_W-1:0] rx_parity_q, rx_parity_d;
  logic              error_q, error_d;

  logic [2:0]        fifo_empty, fifo_full, fifo_flush, fifo_we, fifo_re;
  logic [DATA_W-1:0] fifo_dout [3];
  logic              we, wr_header;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        tgt;
  logic              tgt_empty, tgt_full, tgt_flush;

  assign tgt       = header_q[1:0];
  assign tgt_empty = sel_port(fifo_empty, tgt);
  assign tgt_full  = sel_port(fifo_full, tgt);
  assign tgt_flush = sel_port(fifo_flush, tgt);
  assign fifo_re   = {read_enb_2, read_enb_1, read_enb_0};

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    parity_d    = parity_q;
    rx_parity_d = rx_parity_q;
    error_d     = error_q;
    busy        = 1'b0;
    we          = 1'b0;
    wr_header   = 1'b0;
    wr_data     = data_in;

    unique case (state_q)
      DecodeAddress: begin
        if (pkt_valid) begin
          if (data_in[1:0] == ADDR_INVALID) begin
            state_d = Discard;
          end else begin
            header_d = data_in;
            state_d  = sel_port(fifo_empty, data_in[1:0]) ? LoadFirstData : WaitTillEmpty;
          end
        end
      end
      WaitTillEmpty: begin
        busy = 1'b1;
        if (tgt_empty) state_d = LoadFirstData;
      end
      LoadFirstData: begin
        busy      = 1'b1;
        we        = 1'b1;
        wr_header = 1'b1;
        wr_data   = header_q;
        parity_d  = header_q;
        state_d   = LoadData;
      end
      LoadData: begin
        if (tgt_full) begin
          busy = 1'b1;
        end else begin
          we = 1'b1;
          if (pkt_valid) begin
            parity_d = parity_q ^ data_in;
          end else begin
            rx_parity_d = data_in;
            state_d     = CheckParityError;
          end
        end
      end
      CheckParityError: begin
        busy    = 1'b1;
        error_d = (parity_q != rx_parity_q);
        state_d = DecodeAddress;
      end
      Discard: begin
        if (!pkt_valid) state_d = DecodeAddress;
      end
      default: state_d = DecodeAddress;
    endcase

    // A flushed target FIFO abandons the packet; the held byte is dropped by Discard.
    if (tgt_flush && (state_q == LoadFirstData || state_q == LoadData)) begin
      busy        = 1'b1;
      we          = 1'b0;
      parity_d    = parity_q;
      rx_parity_d = rx_parity_q;
      state_d     = Discard;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= DecodeAddress;
      header_q    <= '0;
      parity_q    <= '0;
      rx_parity_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      parity_q    <= parity_d;
      rx_parity_q <= rx_parity_d;
      error_q     <= error_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_fifo
    assign fifo_we[i] = we && (tgt == 2'(i));

    router_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT    (TIMEOUT)
    ) u_fifo (
      .clock       (clock),
      .resetn      (resetn),
      .write_enb   (fifo_we[i]),
      .read_enb    (fifo_re[i]),
      .header_flag (wr_header),
      .data_in     (wr_data),
      .data_out    (fifo_dout[i]),
      .empty       (fifo_empty[i]),
      .full        (fifo_full[i]),
      .soft_reset  (fifo_flush[i])
    );
  end

  assign data_out_0 = fifo_dout[0];
  assign data_out_1 = fifo_dout[1];
  assign data_out_2 = fifo_dout[2];
  assign vld_out_0  = ~fifo_empty[0];
  assign vld_out_1  = ~fifo_empty[1];
  assign vld_out_2  = ~fifo_empty[2];
  assign error      = error_q;

endmodule

// File: tb/tb_router_1x3.sv
// Directed self-checking bench for router_1x3.
module tb_router_1x3;

  typedef logic [7:0] byte_q_t[$];

  logic       clock = 1'b0;
  logic       resetn;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       error, busy;

  int n_cmp = 0;
  int n_err = 0;
  int busy_seen;

  router_1x3 dut (
    .clock      (clock),
    .resetn     (resetn),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .error      (error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one byte and hold it until the router accepts it.
  task automatic send(input logic [7:0] b, input logic v);
    int guard = 0;
    data_in   = b;
    pkt_valid = v;
    #1;
    while (busy && guard < 200) begin
      busy_seen++;
      guard++;
      tick();
      #1;
    end
    if (busy) check("send_timeout", {31'b0, busy}, 32'd0);
    tick();
  endtask

  task automatic send_pkt(input byte_q_t body, input logic [7:0] par);
    foreach (body[i]) send(body[i], 1'b1);
    send(par, 1'b0);
    pkt_valid = 1'b0;
  endtask

  function automatic logic [7:0] parity_of(input byte_q_t body);
    logic [7:0] p = 8'h00;
    foreach (body[i]) p ^= body[i];
    return p;
  endfunction

  function automatic logic port_vld(input int p);
    case (p)
      0:       return vld_out_0;
      1:       return vld_out_1;
      default: return vld_out_2;
    endcase
  endfunction

  function automatic logic [7:0] port_data(input int p);
    case (p)
      0:       return data_out_0;
      1:       return data_out_1;
      default: return data_out_2;
    endcase
  endfunction

  task automatic set_rd(input int p, input logic v);
    case (p)
      0:       read_enb_0 = v;
      1:       read_enb_1 = v;
      default: read_enb_2 = v;
    endcase
  endtask

  task automatic drain(input int p, input byte_q_t exp, input string tag);
    foreach (exp[i]) begin
      set_rd(p, 1'b1);
      check($sformatf("%s_vld%0d", tag, i), {31'b0, port_vld(p)}, 32'd1);
      check($sformatf("%s_data%0d", tag, i), {24'b0, port_data(p)}, {24'b0, exp[i]});
      tick();
    end
    set_rd(p, 1'b0);
    check({tag, "_empty"}, {31'b0, port_vld(p)}, 32'd0);
  endtask

  initial begin
    byte_q_t    pkt, exp, got, rest;
    logic [7:0] par;

    resetn     = 1'b0;
    read_enb_0 = 1'b0;
    read_enb_1 = 1'b0;
    read_enb_2 = 1'b0;
    pkt_valid  = 1'b0;
    data_in    = 8'h00;
    #3;
    check("rst_vld", {29'b0, vld_out_2, vld_out_1, vld_out_0}, 32'd0);
    check("rst_data", {8'b0, data_out_2, data_out_1, data_out_0}, 32'd0);
    check("rst_err_busy", {30'b0, error, busy}, 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    tick();

    // 16-byte packet to port 1, left unread until fully loaded.
    pkt = {8'h39};
    for (int i = 0; i < 14; i++) pkt.push_back(8'($urandom_range(0, 255)));
    par = parity_of(pkt);
    busy_seen = 0;
    send_pkt(pkt, par);
    check("p1_busy_lfd", busy_seen, 32'd1);
    #1;
    check("p1_busy_chk", {31'b0, busy}, 32'd1);
    check("p1_vld", {31'b0, vld_out_1}, 32'd1);
    tick();
    check("p1_busy_idle", {31'b0, busy}, 32'd0);
    check("p1_error", {31'b0, error}, 32'd0);
    exp = pkt;
    exp.push_back(par);
    drain(1, exp, "p1");

    // Corrupted parity to port 0 (true parity would be 0x0C).
    send_pkt('{8'h0C, 8'h01, 8'h02, 8'h03}, 8'h00);
    tick();
    check("bad_error", {31'b0, error}, 32'd1);
    drain(0, '{8'h0C, 8'h01, 8'h02, 8'h03, 8'h00}, "bad");
    check("bad_error_hold", {31'b0, error}, 32'd1);
    send_pkt('{8'h08, 8'hAA, 8'h55}, 8'hF7);
    tick();
    check("good_error_clr", {31'b0, error}, 32'd0);
    drain(0, '{8'h08, 8'hAA, 8'h55, 8'hF7}, "good");

    // 20-byte packet to port 2: stalls at 16, one byte admitted per pop.
    pkt = {8'h4A};
    for (int i = 0; i < 18; i++) pkt.push_back(8'($urandom_range(0, 255)));
    par = parity_of(pkt);
    for (int i = 0; i < 16; i++) send(pkt[i], 1'b1);
    rest = {pkt[16], pkt[17], pkt[18], par};
    got  = {};
    foreach (rest[i]) begin
      data_in   = rest[i];
      pkt_valid = (i < 3);
      #1;
      if (i == 0) begin
        repeat (3) tick();
        #1;
      end
      check($sformatf("ovf_stall%0d", i), {31'b0, busy}, 32'd1);
      read_enb_2 = 1'b1;
      got.push_back(data_out_2);
      tick();
      read_enb_2 = 1'b0;
      #1;
      check($sformatf("ovf_accept%0d", i), {31'b0, busy}, 32'd0);
      tick();
    end
    pkt_valid = 1'b0;
    tick();
    check("ovf_error", {31'b0, error}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      read_enb_2 = 1'b1;
      got.push_back(data_out_2);
      tick();
    end
    read_enb_2 = 1'b0;
    check("ovf_empty", {31'b0, vld_out_2}, 32'd0);
    exp = pkt;
    exp.push_back(par);
    check("ovf_count", got.size(), exp.size());
    foreach (exp[i]) check($sformatf("ovf_byte%0d", i), {24'b0, got[i]}, {24'b0, exp[i]});

    // Back-to-back packets to port 0: second header waits until FIFO 0 drains.
    send_pkt('{8'h04, 8'h11}, 8'h15);
    send(8'h04, 1'b1);
    data_in   = 8'h22;
    pkt_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b_wait%0d", i), {31'b0, busy}, 32'd1);
      tick();
    end
    drain(0, '{8'h04, 8'h11, 8'h15}, "b2b_a");
    send(8'h22, 1'b1);
    send(8'h26, 1'b0);
    pkt_valid = 1'b0;
    tick();
    check("b2b_error", {31'b0, error}, 32'd0);
    drain(0, '{8'h04, 8'h22, 8'h26}, "b2b_b");

    // Invalid address 3: whole packet dropped, router ready for the next one.
    busy_seen = 0;
    send_pkt('{8'h07, 8'h99}, 8'h9E);
    tick();
    check("inv_busy", busy_seen, 32'd0);
    check("inv_vld", {29'b0, vld_out_2, vld_out_1, vld_out_0}, 32'd0);
    send_pkt('{8'h06, 8'h33}, 8'h35);
    tick();
    check("inv_next_err", {31'b0, error}, 32'd0);
    drain(2, '{8'h06, 8'h33, 8'h35}, "inv_next");

    // Asynchronous reset in the middle of a packet.
    send_pkt('{8'h02}, 8'hFF);
    tick();
    check("mid_pre_err", {31'b0, error}, 32'd1);
    send(8'h09, 1'b1);
    send(8'hAB, 1'b1);
    check("mid_pre_vld", {30'b0, vld_out_2, vld_out_1}, 32'd3);
    #2;
    resetn    = 1'b0;
    pkt_valid = 1'b0;
    #1;
    check("mid_vld", {29'b0, vld_out_2, vld_out_1, vld_out_0}, 32'd0);
    check("mid_data", {8'b0, data_out_2, data_out_1, data_out_0}, 32'd0);
    check("mid_err_busy", {30'b0, error, busy}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    send_pkt('{8'h05, 8'h44}, 8'h41);
    tick();
    check("mid_after_err", {31'b0, error}, 32'd0);
    drain(1, '{8'h05, 8'h44, 8'h41}, "mid_after");

`ifdef SOFT_RESET_EN
    // Unread FIFO 0 is flushed after 30 idle cycles; a pop at cycle 29 saves it.
    send_pkt('{8'h04, 8'h11}, 8'h15);
    repeat (27) tick();
    check("to_before", {31'b0, vld_out_0}, 32'd1);
    tick();
    check("to_flush", {31'b0, vld_out_0}, 32'd0);
    send_pkt('{8'h04, 8'h11}, 8'h15);
    repeat (26) tick();
    read_enb_0 = 1'b1;
    tick();
    read_enb_0 = 1'b0;
    tick();
    check("to_saved", {31'b0, vld_out_0}, 32'd1);
    drain(0, '{8'h11, 8'h15}, "to_rest");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_1x3.md
Name: router_1x3

Overview:
- 1-input, 3-output byte-serial packet router.
- A source streams packets on data_in, framed by pkt_valid. The block decodes the 2-bit destination address in the header and buffers the whole packet (header, payload, parity) in one of three output FIFOs.
- Each output port drains independently via its own read enable.
- A parity check on every packet drives error.

Parameters:
- DATA_W, 8, byte width of data_in / data_out_n.
- FIFO_DEPTH, 16, entries per output FIFO (power of two).
- TIMEOUT, 30, idle cycles before an unread FIFO is flushed (optional feature).

Ports:
- clock  in  1  single rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- read_enb_0  in  1  pop request, output 0.
- read_enb_1  in  1  pop request, output 1.
- read_enb_2  in  1  pop request, output 2.
- pkt_valid  in  1  high for header and payload bytes; low on the parity byte.
- data_in  in  8  packet byte.
- data_out_0  out  8  head-of-FIFO byte, output 0.
- data_out_1  out  8  head-of-FIFO byte, output 1.
- data_out_2  out  8  head-of-FIFO byte, output 2.
- vld_out_0  out  1  FIFO 0 not empty.
- vld_out_1  out  1  FIFO 1 not empty.
- vld_out_2  out  1  FIFO 2 not empty.
- error  out  1  parity mismatch on last completed packet.
- busy  out  1  input not accepted this cycle; source must hold data_in and pkt_valid.

Behaviour:
Interface and reset
- One clock; reset is asynchronous and active-low.
- Reset values: all FIFOs empty, vld_out_n=0, data_out_n=0, error=0, busy=0, FSM in DECODE_ADDRESS, parity register=0.

Packet format
- Header = {length[7:2], addr[1:0]}. Length is informational only; pkt_valid alone frames the packet.
- Payload bytes follow the header with pkt_valid=1.
- Parity byte is the first byte with pkt_valid=0. It equals the XOR of header and all payload bytes.
- addr 0/1/2 select FIFO 0/1/2. addr 3 is invalid.

Input FSM (busy is combinational)
- DECODE_ADDRESS, busy=0. On pkt_valid=1:
  - addr=3: go to DISCARD.
  - Target FIFO empty: latch header and addr, go to LOAD_FIRST_DATA.
  - Target FIFO not empty: latch header and addr, go to WAIT_TILL_EMPTY.
- WAIT_TILL_EMPTY, busy=1. Go to LOAD_FIRST_DATA when the target FIFO is empty.
- LOAD_FIRST_DATA, busy=1. Write latched header to the target FIFO; parity reg = header. Go to LOAD_DATA.
- LOAD_DATA:
  - Target FIFO full: busy=1, no write, stay.
  - pkt_valid=1 and not full: write data_in, parity ^= data_in.
  - pkt_valid=0 and not full: write data_in (the parity byte), capture it as received parity, go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR, busy=1. error <= (computed != received). Go to DECODE_ADDRESS. error holds until the next packet's check.
- DISCARD, busy=0. Ignore all bytes. Return to DECODE_ADDRESS on the cycle pkt_valid=0 (that parity byte is also dropped).

Output FIFO (per port)
- Entries are 9 bits: byte plus header flag.
- First-word-fall-through: data_out_n = head byte when non-empty, else 0. vld_out_n = ~empty.
- Pop on read_enb_n & vld_out_n; next entry is visible the following cycle.
- read_enb_n while empty is ignored.
- Simultaneous push and pop on a non-full FIFO: both occur, occupancy unchanged.
- Full is evaluated before the pop, so a full FIFO stalls the input even if it is being popped that cycle.

Optional Feature:
SOFT_RESET_EN
- Defined:
  - A per-port 5-bit counter increments while vld_out_n=1 and read_enb_n=0.
  - It clears on any pop or when the FIFO is empty.
  - Reaching TIMEOUT flushes that FIFO (empty next cycle) and clears the counter.
  - If the FSM is mid-packet into that FIFO, the FSM goes to DISCARD and error is unchanged.
- Undefined: no counters; FIFOs hold data indefinitely.

Decomposition:
- Package router_pkg:
  - state enum (DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, CHECK_PARITY_ERROR, DISCARD).
  - ADDR_INVALID=2'd3.
  - DATA_W, FIFO_DEPTH, TIMEOUT defaults.
- Sub-module router_fifo (sync FIFO with FWFT output and optional soft reset), instantiated three times.
- FSM, header latch and parity logic stay in the top.

Test Plan:
- Reset mid-packet: assert resetn=0 asynchronously -> all outputs 0 immediately, FSM idle; a following clean packet routes correctly.
- Packet to port 1: header 0x39 (len 14, addr 1), 14 random bytes, correct parity byte, read_enb_1=0 -> busy=1 for exactly the LOAD_FIRST_DATA cycle and the parity-check cycle; vld_out_1=1; FIFO 1 holds 16 bytes. Then set read_enb_1=1 -> 0x39 first, parity byte last, vld_out_1 falls after 16 pops; error=0.
- Corrupted parity to port 0 (header 0x0C, payload 0x01,0x02,0x03, parity 0x00) -> error=1 one cycle after the parity byte; next good packet clears error.
- Overflow: 20-byte packet to port 2 with read_enb_2=0 -> busy stays high once FIFO 2 holds 16; pulsing read_enb_2 accepts one byte per pop; no byte is lost or duplicated.
- Back-to-back packets to the same port with the FIFO non-empty -> WAIT_TILL_EMPTY holds busy=1 until drained. Invalid addr 3 packet -> nothing written, vld_out all 0.
- With SOFT_RESET_EN: leave FIFO 0 unread 30 cycles -> vld_out_0 drops to 0; reading at cycle 29 prevents the flush.
